// File: rtl/decoder_pkg.sv
// Shared decoder types and helpers: FSM state encoding and a code-to-one-hot
// mapping reusable by any decoder width up to MAX_N outputs.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam int unsigned MAX_N = 256;
  localparam int unsigned MAX_W = 9;

  // Returns bit (code-1) set for code in 1..n; all zero for code 0 or code > n.
  // Callers truncate the result to their own output width.
  function automatic logic [MAX_N-1:0] code_to_onehot(input logic [MAX_W-1:0] code,
                                                      input int unsigned      n);
    logic [MAX_N-1:0] oh;
    oh = '0;
    if ((code != '0) && ({23'd0, code} <= n)) begin
      oh = MAX_N'(1) << (code - MAX_W'(1));
    end
    return oh;
  endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled and pulses
// tc_o on the last count so the caller advances exactly every DWELL cycles.
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-way one-hot decoder with valid/ready input, out-of-range error
// pulse, and a self-timed scan mode that walks one active bit across y.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned  N     = 16,
  parameter int unsigned  DWELL = 4,
  localparam int unsigned W     = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  output logic [N-1:0] y,
  output logic         y_valid,
  output logic         err,
  output logic         scan_wrap,
  output logic [1:0]   state_dbg
);

  localparam int unsigned   IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_tc;
  logic          accept;
  logic          code_zero;
  logic          code_over;

  // Handshake: a code is taken on a rising edge where in_valid && in_ready.
  // in_ready depends only on mode and state (never on in_valid), so a source
  // may hold in_valid high across scan mode; those codes are simply ignored.
  assign in_ready  = (state_q != SCAN) && !mode;
  assign accept    = in_valid && in_ready;
  assign code_zero = (in_code == '0);
  assign code_over = (32'(in_code) > N);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    if (mode) begin
      if (state_q != SCAN) begin
        state_d   = SCAN;
        idx_d     = '0;
        y_d       = N'(1);
        y_valid_d = 1'b1;
        tmr_clr   = 1'b1;
      end else begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          // Explicit wrap keeps non-power-of-two N from visiting unused indices.
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
          y_d = N'(1) << idx_d;
        end
      end
    end else if (state_q == SCAN) begin
      state_d   = IDLE;
      idx_d     = '0;
      y_d       = '0;
      y_valid_d = 1'b0;
      tmr_clr   = 1'b1;
    end else if (accept) begin
      y_d       = N'(code_to_onehot(MAX_W'(in_code), N));
      y_valid_d = !code_zero && !code_over;
      state_d   = (!code_zero && !code_over) ? HOLD : IDLE;
      err_d     = code_over;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign err       = err_q;
  assign scan_wrap = wrap_q;
  assign state_dbg = state_q;

endmodule
